// File: rtl/mem_responder_if.sv
// Request/response bus between a single initiator and mem_responder.
//   req_read   : load request, held stable while stall is high
//   req_write  : store request, held stable while stall is high
//   req_addr   : byte address (word aligned for a legal access)
//   req_wdata  : store data
//   rdata      : registered load data
//   stall      : initiator must freeze PC and request while high
//   ack        : one-cycle completion pulse
//   err        : the presented request is illegal
interface mem_responder_if;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        ack;
  logic        err;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  rdata, stall, ack, err
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output rdata, stall, ack, err
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency single-port memory responder.
// Each legal access spends one IDLE cycle plus LATENCY WAIT cycles with stall high, then one DONE
// cycle with ack high. Loads update rdata on the WAIT->DONE edge; stores commit on the same edge.
// Ports:
//   sys_clk : clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : mem_responder_if slave modport (request in, rdata/stall/ack/err out)
module mem_responder #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic           sys_clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] rdata_q;
  logic        ack_q;

  // No reset on the array so it maps onto block RAM.
  logic [31:0] mem_q [Words];

  logic                  one_hot_req;
  logic                  req_any;
  logic                  aligned;
  logic                  in_range;
  logic                  req_valid;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  mem_we;

  assign one_hot_req = bus.req_read ^ bus.req_write;
  assign req_any     = bus.req_read | bus.req_write;
  assign aligned     = (bus.req_addr[1:0] == 2'b00);
  assign in_range    = ((bus.req_addr >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign req_valid   = one_hot_req & aligned & in_range;
  assign word_idx    = bus.req_addr[DEPTH_LOG2+1:2];

  // Store commits only on the final WAIT edge of a request that is still intact.
  assign mem_we = (state_q == StWait) && req_valid && (cnt_q == 4'd0) && bus.req_write;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            state_q <= StWait;
            cnt_q   <= 4'(LATENCY - 1);
          end
        end
        StWait: begin
          // A request that drops (or otherwise stops being legal) abandons the access.
          if (!req_valid) begin
            state_q <= StIdle;
          end else if (cnt_q == 4'd0) begin
            state_q <= StDone;
            ack_q   <= 1'b1;
            if (bus.req_read) begin
              rdata_q <= mem_q[word_idx];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (mem_we) begin
      mem_q[word_idx] <= bus.req_wdata;
    end
  end

  // stall in IDLE is combinational so the initiator freezes in the same cycle it asks.
  assign bus.stall = (state_q == StIdle) ? req_valid : (state_q == StWait);
  assign bus.err   = (state_q == StIdle) && req_any && !req_valid;
  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: two instances (LATENCY=1 and LATENCY=2) share a clock
// and reset; one is exercised at a time through a selector. A word-level reference model tracks
// memory contents and the last loaded value.
module tb_mem_responder;

  localparam int Words = 1024;

  logic sys_clk = 1'b0;
  logic rst;

  always #5 sys_clk = ~sys_clk;

  mem_responder_if u_if_l1 ();
  mem_responder_if u_if_l2 ();

  mem_responder #(.LATENCY(1), .DEPTH_LOG2(10)) u_dut_l1 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (u_if_l1.slave)
  );

  mem_responder #(.LATENCY(2), .DEPTH_LOG2(10)) u_dut_l2 (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (u_if_l2.slave)
  );

  int          sel;
  logic        drv_rd;
  logic        drv_wr;
  logic [31:0] drv_addr;
  logic [31:0] drv_wdata;

  assign u_if_l1.req_read  = (sel == 0) ? drv_rd : 1'b0;
  assign u_if_l1.req_write = (sel == 0) ? drv_wr : 1'b0;
  assign u_if_l1.req_addr  = (sel == 0) ? drv_addr : 32'd0;
  assign u_if_l1.req_wdata = (sel == 0) ? drv_wdata : 32'd0;
  assign u_if_l2.req_read  = (sel == 1) ? drv_rd : 1'b0;
  assign u_if_l2.req_write = (sel == 1) ? drv_wr : 1'b0;
  assign u_if_l2.req_addr  = (sel == 1) ? drv_addr : 32'd0;
  assign u_if_l2.req_wdata = (sel == 1) ? drv_wdata : 32'd0;

  logic        obs_stall;
  logic        obs_ack;
  logic        obs_err;
  logic [31:0] obs_rdata;

  assign obs_stall = (sel == 0) ? u_if_l1.stall : u_if_l2.stall;
  assign obs_ack   = (sel == 0) ? u_if_l1.ack : u_if_l2.ack;
  assign obs_err   = (sel == 0) ? u_if_l1.err : u_if_l2.err;
  assign obs_rdata = (sel == 0) ? u_if_l1.rdata : u_if_l2.rdata;

  // Reference model
  logic [31:0] ref_mem   [2][Words];
  bit          ref_known [2][Words];
  logic [31:0] ref_rdata [2];

  int nvec = 0;
  int nbad = 0;

  function automatic int lat_of(input int s);
    return (s == 0) ? 1 : 2;
  endfunction

  function automatic bit is_legal(input bit rd, input bit wr, input logic [31:0] a);
    return ((int'(rd) + int'(wr)) == 1) && ((a % 4) == 0) && (a < 32'(4 * Words));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    drv_rd    = 1'b0;
    drv_wr    = 1'b0;
    drv_addr  = 32'd0;
    drv_wdata = 32'd0;
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    drv_rd    = rd;
    drv_wr    = wr;
    drv_addr  = a;
    drv_wdata = d;
  endtask

  // Request already on the bus with the DUT in IDLE: follow it to its ack and check it.
  task automatic await_ack(input int s, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int          n_stall;
    bit          got;
    bit          saw_err;
    logic [31:0] rd_seen;
    int          idx;
    n_stall = 0;
    got     = 1'b0;
    saw_err = 1'b0;
    rd_seen = 32'd0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge sys_clk);
      if (obs_stall) n_stall++;
      if (obs_err) saw_err = 1'b1;
      if (obs_ack) begin
        got     = 1'b1;
        rd_seen = obs_rdata;
      end
    end
    check("ack_seen", 32'(got), 32'd1);
    check("stall_cycles", 32'(n_stall), 32'(lat_of(s) + 1));
    check("err_on_valid", 32'(saw_err), 32'd0);
    idx = int'(a >> 2);
    if (wr) begin
      check("rdata_hold_on_write", rd_seen, ref_rdata[s]);
      ref_mem[s][idx]   = d;
      ref_known[s][idx] = 1'b1;
    end else begin
      ref_rdata[s] = ref_mem[s][idx];
      check("rdata_load", rd_seen, ref_rdata[s]);
    end
  endtask

  task automatic release_bus();
    @(posedge sys_clk); #1;
    idle_bus();
    @(negedge sys_clk);
    check("ack_one_cycle", 32'(obs_ack), 32'd0);
    check("stall_after", 32'(obs_stall), 32'd0);
    check("err_idle", 32'(obs_err), 32'd0);
  endtask

  task automatic request(input int s, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d);
    sel = s;
    @(posedge sys_clk); #1;
    drive(rd, wr, a, d);
    if (is_legal(rd, wr, a)) begin
      await_ack(s, wr, a, d);
    end else begin
      for (int c = 0; c < 2; c++) begin
        @(negedge sys_clk);
        check("illegal_err", 32'(obs_err), 32'd1);
        check("illegal_stall", 32'(obs_stall), 32'd0);
        check("illegal_ack", 32'(obs_ack), 32'd0);
        check("illegal_rdata", obs_rdata, ref_rdata[s]);
      end
    end
    release_bus();
  endtask

  int          r_s;
  int          r_k;
  bit          r_rd;
  logic [31:0] r_a;
  logic [31:0] r_d;

  initial begin
    sel = 0;
    idle_bus();
    for (int s = 0; s < 2; s++) begin
      ref_rdata[s] = 32'd0;
      for (int w = 0; w < Words; w++) begin
        ref_known[s][w] = 1'b0;
        ref_mem[s][w]   = 32'd0;
      end
    end

    // Reset state
    rst = 1'b1;
    #12;
    check("rst_rdata_l1", u_if_l1.rdata, 32'd0);
    check("rst_ack_l1", 32'(u_if_l1.ack), 32'd0);
    check("rst_stall_l1", 32'(u_if_l1.stall), 32'd0);
    check("rst_err_l1", 32'(u_if_l1.err), 32'd0);
    check("rst_rdata_l2", u_if_l2.rdata, 32'd0);
    check("rst_ack_l2", 32'(u_if_l2.ack), 32'd0);
    check("rst_stall_l2", 32'(u_if_l2.stall), 32'd0);
    check("rst_err_l2", 32'(u_if_l2.err), 32'd0);
    @(negedge sys_clk);
    rst = 1'b0;

    // LATENCY=2 store then load
    request(1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    request(1, 1'b1, 1'b0, 32'h10, 32'd0);

    // LATENCY=1 store then load
    request(0, 1'b0, 1'b1, 32'h0, 32'h12345678);
    request(0, 1'b1, 1'b0, 32'h0, 32'd0);

    // Misaligned, out of range, and both-strobes requests leave memory alone
    request(1, 1'b0, 1'b1, 32'h13, 32'h0BADBAD0);
    request(1, 1'b0, 1'b1, 32'h1000, 32'h0BADBAD1);
    request(1, 1'b1, 1'b1, 32'h10, 32'h55555555);
    request(1, 1'b1, 1'b0, 32'h10, 32'd0);

    // Store to 0x20 dropped in the second WAIT cycle
    request(1, 1'b0, 1'b1, 32'h20, 32'h11112222);
    sel = 1;
    @(posedge sys_clk); #1;
    drive(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
    @(posedge sys_clk); #1;
    @(posedge sys_clk); #1;
    idle_bus();
    @(negedge sys_clk);
    check("abort_wait_stall", 32'(obs_stall), 32'd1);
    check("abort_wait_ack", 32'(obs_ack), 32'd0);
    @(negedge sys_clk);
    check("abort_idle_stall", 32'(obs_stall), 32'd0);
    check("abort_idle_ack", 32'(obs_ack), 32'd0);
    check("abort_rdata", obs_rdata, ref_rdata[1]);
    request(1, 1'b1, 1'b0, 32'h20, 32'd0);

    // Back-to-back: a load follows the store's DONE cycle with no idle gap
    sel = 0;
    @(posedge sys_clk); #1;
    drive(1'b0, 1'b1, 32'h44, 32'h600DF00D);
    await_ack(0, 1'b1, 32'h44, 32'h600DF00D);
    @(posedge sys_clk); #1;
    drive(1'b1, 1'b0, 32'h44, 32'd0);
    await_ack(0, 1'b0, 32'h44, 32'd0);
    release_bus();

    // Reset during WAIT of a store to 0x30
    request(1, 1'b0, 1'b1, 32'h30, 32'h0BAD0030);
    request(1, 1'b1, 1'b0, 32'h10, 32'd0);
    sel = 1;
    @(posedge sys_clk); #1;
    drive(1'b0, 1'b1, 32'h30, 32'hCAFEF00D);
    @(posedge sys_clk); #1;
    rst = 1'b1;
    idle_bus();
    #1;
    check("rstwait_rdata", obs_rdata, 32'd0);
    check("rstwait_ack", 32'(obs_ack), 32'd0);
    check("rstwait_stall", 32'(obs_stall), 32'd0);
    ref_rdata[0] = 32'd0;
    ref_rdata[1] = 32'd0;
    @(posedge sys_clk); #1;
    rst = 1'b0;
    @(negedge sys_clk);
    check("post_rst_stall", 32'(obs_stall), 32'd0);
    check("post_rst_ack", 32'(obs_ack), 32'd0);
    request(1, 1'b1, 1'b0, 32'h30, 32'd0);

    // Randomized mix against the model
    for (int i = 0; i < 80; i++) begin
      r_s  = int'($urandom_range(0, 1));
      r_k  = int'($urandom_range(0, 9));
      r_a  = 32'($urandom_range(0, 15)) * 32'd4;
      r_d  = $urandom;
      r_rd = 1'($urandom_range(0, 1));
      if (r_k < 4) begin
        request(r_s, 1'b0, 1'b1, r_a, r_d);
      end else if (r_k < 7) begin
        if (ref_known[r_s][r_a >> 2]) request(r_s, 1'b1, 1'b0, r_a, 32'd0);
        else request(r_s, 1'b0, 1'b1, r_a, r_d);
      end else if (r_k == 7) begin
        request(r_s, r_rd, !r_rd, r_a | 32'($urandom_range(1, 3)), r_d);
      end else if (r_k == 8) begin
        request(r_s, r_rd, !r_rd, r_a + 32'h1000 + 32'($urandom_range(0, 4095)) * 32'd4, r_d);
      end else begin
        request(r_s, 1'b1, 1'b1, r_a, r_d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have the parameter LATENCY, default 2, meaning the number of WAIT cycles per access; legal range 1..15.
REQ-002 The module SHALL have the parameter DEPTH_LOG2, default 10, meaning log2 of the word count of internal storage (1024 words, 4 KiB).
REQ-003 The module SHALL have port sys_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port req_read, input, 1 bit: load request, held stable by the initiator while stall=1.
REQ-006 The module SHALL have port req_write, input, 1 bit: store request, held stable while stall=1.
REQ-007 The module SHALL have port req_addr, input, 32 bits: byte address; word index is req_addr[DEPTH_LOG2+1:2].
REQ-008 The module SHALL have port req_wdata, input, 32 bits: store data.
REQ-009 The module SHALL have port rdata, output, 32 bits: load data, registered.
REQ-010 The module SHALL have port stall, output, 1 bit: the initiator must freeze PC and request while high.
REQ-011 The module SHALL have port ack, output, 1 bit: one-cycle completion pulse.
REQ-012 The module SHALL have port err, output, 1 bit: the current request is illegal.

Function
REQ-013 The block SHALL implement a 3-state FSM (IDLE, WAIT, DONE) with a 4-bit down-counter.
REQ-014 A request is valid when exactly one of req_read/req_write is 1, req_addr[1:0]=0 and req_addr < 4*2^DEPTH_LOG2.
REQ-015 In IDLE, stall SHALL be combinationally 1 when the request is valid, else 0.
REQ-016 On an edge in IDLE with a valid request, the FSM SHALL move IDLE->WAIT and load the counter with LATENCY-1.
REQ-017 In WAIT, stall SHALL be 1, and the counter SHALL decrement each edge while it is nonzero.
REQ-018 On an edge in WAIT with counter=0, the FSM SHALL move to DONE; on that same edge, a write stores req_wdata to the addressed word, and a read registers the addressed word into rdata.
REQ-019 In DONE, stall SHALL be 0 and ack SHALL be 1; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-020 Total stall SHALL be exactly LATENCY+1 cycles per valid access, and ack SHALL be high for exactly 1 cycle.
REQ-021 A request that deasserts (req_read=req_write=0) while in WAIT SHALL abort: next edge -> IDLE, no write, rdata unchanged, no ack.
REQ-022 For an illegal request (misaligned, out of range, or read and write both 1), err SHALL be combinationally 1 in IDLE, stall 0, no state change, no write, and rdata SHALL be unchanged.
REQ-023 err SHALL be 0 in WAIT and DONE.
REQ-024 rdata SHALL hold its last value across writes, aborts and idle cycles.
REQ-025 A new valid request presented in the cycle immediately after DONE SHALL start a fresh access, with no back-to-back bypass.
REQ-026 Storage SHALL be a synchronous-write array, not cleared by reset, so that it infers block RAM.

Reset
REQ-027 While rst=1, the FSM SHALL be in IDLE, the counter SHALL be 0, rdata SHALL be 0 and ack SHALL be 0; stall and err follow REQ-015/REQ-022.
REQ-028 Reset asserted in WAIT SHALL abort the access, with no write committed; memory contents SHALL be preserved.
REQ-029 After rst falls, the first valid request SHALL behave per REQ-016.

Verification
REQ-030 LATENCY=2, write addr 0x10, data 0xDEADBEEF -> stall high for 3 cycles, ack for 1 cycle; a subsequent read of 0x10 -> rdata=0xDEADBEEF in the ack cycle.
REQ-031 LATENCY=1, read of 0x0 after writing 0x12345678 -> stall for exactly 2 cycles, then rdata=0x12345678.
REQ-032 Write addr 0x13 (misaligned) or 0x1000 (out of range) -> err=1, stall=0, and a readback of 0x10 is unchanged.
REQ-033 req_read=req_write=1 -> err=1, no ack, and no memory change.
REQ-034 Write to 0x20 with data 0xA5A5A5A5, request dropped in the 2nd WAIT cycle -> no ack, FSM in IDLE next cycle, and readback of 0x20 is unchanged from its prior value.
REQ-035 rst pulsed during WAIT of a write of 0xCAFEF00D to 0x30 -> rdata=0, FSM IDLE, and readback of 0x30 shows the old value.
